// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/forward_select.sv
// Per-operand bypass selection: the Memory-stage result is newer than the
// Writeback-stage result, so it wins when both match.
module forward_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output fwd_sel_t   sel
);

  // Priority bypass decode; x0 is never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != REG_X0) && (rd_m == rs_e)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != REG_X0) && (rd_w == rs_e)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward scheduler for the 5-stage RV32 pipeline, with a
// data-memory watchdog and stall/flush performance counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 ResultSrcE0,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 PCSrcE,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] StallCycles,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  hz_state_t     state;
  hz_state_t     state_next;
  logic [WW-1:0] waitcnt;
  logic [WW-1:0] waitcnt_next;
  fwd_sel_t      fwd_a;
  fwd_sel_t      fwd_b;
  logic          lw_stall;
  logic          mem_stall;
  logic          halt_active;

  forward_select u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_a)
  );

  forward_select u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_b)
  );

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  assign lw_stall  = ResultSrcE0 && (RdE != REG_X0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
  assign mem_stall = MemReqM && !MemReadyM;
  // Reset forces the RUN equations even while the state register still reads HALT.
  assign halt_active = (state == HALT) && !rst;

  // Stall and flush outputs.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (halt_active) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall || mem_stall;
      StallD = lw_stall || mem_stall;
      StallE = mem_stall;
      StallM = mem_stall;
      FlushW = mem_stall;
      FlushD = PCSrcE && !mem_stall;
      FlushE = (lw_stall || PCSrcE) && !mem_stall;
    end
  end

  // Next-state and wait-counter logic for the memory watchdog.
  always_comb begin
    state_next   = state;
    waitcnt_next = waitcnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_next   = MEM_WAIT;
          waitcnt_next = WW'(1);
        end else begin
          state_next   = RUN;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_next   = RUN;
          waitcnt_next = '0;
        end else if (waitcnt == WAIT_LAST) begin
          state_next   = HALT;
        end else begin
          waitcnt_next = waitcnt + WW'(1);
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next   = RUN;
        waitcnt_next = '0;
      end
    endcase
  end

  // State, halt flag and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      waitcnt     <= '0;
      Halted      <= 1'b0;
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      state       <= state_next;
      waitcnt     <= waitcnt_next;
      Halted      <= (state_next == HALT);
      StallCycles <= StallCycles + {{(CNT_WIDTH-1){1'b0}}, StallF};
      FlushCount  <= FlushCount + {{(CNT_WIDTH-1){1'b0}}, FlushD};
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a spec-level model pushes expected
// outputs into a scoreboard queue, which is popped and checked each cycle.
module tb_hazard_controller;

  localparam int MT = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, Halted;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] StallCycles, FlushCount;

  int checks = 0;
  int failures = 0;

  logic [11:0] sb_q[$];
  logic [11:0] last_exp;
  int          m_state;
  int          m_wait;
  logic        m_halted;
  logic [CW-1:0] m_stall, m_flush;

  hazard_controller #(.MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .Halted(Halted),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] mfwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    else return 2'b00;
  endfunction

  // Expected {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA,FwdB,Halted}.
  function automatic logic [11:0] model_out();
    logic lw, ms;
    logic [6:0] ctl;
    lw = ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D) && !PCSrcE;
    ms = MemReqM && !MemReadyM;
    if (m_state == 2 && !rst) ctl = 7'b1111001;
    else ctl = {lw | ms, lw | ms, ms, ms, PCSrcE & ~ms, (lw | PCSrcE) & ~ms, ms};
    return {ctl, mfwd(Rs1E), mfwd(Rs2E), m_halted};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic ms;
    ms = MemReqM && !MemReadyM;
    if (rst) begin
      m_state = 0; m_wait = 0; m_halted = 1'b0; m_stall = '0; m_flush = '0;
    end else begin
      m_stall = m_stall + CW'(last_exp[11]);
      m_flush = m_flush + CW'(last_exp[7]);
      case (m_state)
        0: if (ms) begin m_state = 1; m_wait = 1; end
        1: begin
          if (!ms) begin m_state = 0; m_wait = 0; end
          else if (m_wait == MT - 1) m_state = 2;
          else m_wait++;
        end
        default: m_state = 2;
      endcase
      m_halted = (m_state == 2);
    end
  endtask

  // One cycle: inputs already driven; check outputs, clock, check counters.
  task automatic step(input string tag);
    logic [11:0] exp;
    #1;
    last_exp = model_out();
    sb_q.push_back(last_exp);
    exp = sb_q.pop_front();
    check(tag, {20'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                ForwardAE, ForwardBE, Halted}, {20'd0, exp});
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_cnt"}, {24'd0, StallCycles, FlushCount}, {24'd0, m_stall, m_flush});
    check({tag, "_halted"}, {31'd0, Halted}, {31'd0, m_halted});
    @(negedge clk);
  endtask

  task automatic idle();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    ResultSrcE0 = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("reset");
    rst = 1'b0;
  endtask

  initial begin
    m_state = 0; m_wait = 0; m_halted = 1'b0; m_stall = '0; m_flush = '0;
    idle();
    do_reset();
    check("reset_stallcnt", {28'd0, StallCycles}, 32'd0);
    check("reset_halted", {31'd0, Halted}, 32'd0);

    // Forwarding priority
    Rs1E = 5'd5; Rs2E = 5'd9; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
    step("fwd_mem_prio");
    check("fwd_a_mem", {30'd0, ForwardAE}, 32'd2);
    RegWriteM = 1'b0;
    step("fwd_wb");
    check("fwd_a_wb", {30'd0, ForwardAE}, 32'd1);
    RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
    step("fwd_x0");
    check("fwd_a_rf", {30'd0, ForwardAE}, 32'd0);
    RdM = 5'd9; RdW = 5'd5;
    step("fwd_split");

    // Load-use
    idle(); do_reset();
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    step("loaduse");
    check("loaduse_cnt", {28'd0, StallCycles}, 32'd1);
    RdE = 5'd0; Rs2D = 5'd0;
    step("loaduse_x0");
    check("loaduse_x0_cnt", {28'd0, StallCycles}, 32'd1);

    // Branch squashes the load-use bubble
    RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
    step("branch_flush");
    check("branch_flushcnt", {28'd0, FlushCount}, 32'd1);

    // Memory wait with a concurrent taken branch
    idle(); do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) step("memwait");
    MemReadyM = 1'b1;
    step("memwait_done");
    check("memwait_stallcnt", {28'd0, StallCycles}, 32'd3);
    check("memwait_flushcnt", {28'd0, FlushCount}, 32'd1);
    idle();
    step("memwait_back_run");

    // Load-use under a memory stall
    ResultSrcE0 = 1'b1; RdE = 5'd3; Rs1D = 5'd3; MemReqM = 1'b1; MemReadyM = 1'b0;
    step("lw_memstall");
    MemReadyM = 1'b1;
    step("lw_after_mem");

    // Timeout and halt
    idle(); do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < MT; i++) step("timeout");
    check("halted_set", {31'd0, Halted}, 32'd1);
    MemReadyM = 1'b1; PCSrcE = 1'b1;
    step("halt_ignore_ready");
    step("halt_hold");
    check("halt_stallcnt", {28'd0, StallCycles}, 32'd6);
    check("halt_flushcnt", {28'd0, FlushCount}, 32'd0);
    rst = 1'b1;
    step("halt_reset");
    rst = 1'b0;
    check("halt_reset_halted", {31'd0, Halted}, 32'd0);
    check("halt_reset_cnt", {28'd0, StallCycles}, 32'd0);
    idle();
    step("post_halt_run");

    // Counter wrap at 4 bits
    idle(); do_reset();
    ResultSrcE0 = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
    for (int i = 0; i < 17; i++) step("wrap");
    check("wrap_stallcnt", {28'd0, StallCycles}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline scheduler for the 5-stage RV32 core: it produces stall, flush and forwarding controls for the F/D/E/M/W pipeline registers.
- Resolves load-use hazards, taken branches/jumps and multi-cycle data-memory waits.
- Halts the pipeline if data memory does not respond within a time limit.
- Keeps stall/flush performance counters.
- Sits beside the datapath and consumes register indices from the decode and later stages.

Parameters:
MEM_TIMEOUT, 64, number of consecutive not-ready cycles after which the pipeline halts (must be ≥2)
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
Rs1D  in  5  source register 1 of the instruction in Decode
Rs2D  in  5  source register 2 in Decode
Rs1E  in  5  source register 1 in Execute
Rs2E  in  5  source register 2 in Execute
RdE  in  5  destination register in Execute
RdM  in  5  destination register in Memory
RdW  in  5  destination register in Writeback
ResultSrcE0  in  1  Execute instruction is a load (ResultSrc bit 0)
RegWriteM  in  1  Memory-stage instruction writes the register file
RegWriteW  in  1  Writeback-stage instruction writes the register file
PCSrcE  in  1  branch taken or jump in Execute
MemReqM  in  1  Memory-stage instruction accesses data memory
MemReadyM  in  1  data memory completes the access this cycle
StallF  out  1  hold PC
StallD  out  1  hold the F/D register
StallE  out  1  hold the D/E register
StallM  out  1  hold the E/M register
FlushD  out  1  clear the F/D register
FlushE  out  1  clear the D/E register
FlushW  out  1  clear the M/W register (insert bubble)
ForwardAE  out  2  SrcA select: 00 = register file, 01 = ResultW, 10 = ALUResultM
ForwardBE  out  2  SrcB select, same encoding
Halted  out  1  sticky memory-timeout indication
StallCycles  out  CNT_WIDTH  count of cycles with StallF=1
FlushCount  out  CNT_WIDTH  count of cycles with FlushD=1

Behaviour:
- Forwarding is combinational, evaluated per operand with X in {A, B}.
  - Select 10 if RegWriteM, RdM≠0 and RdM==RsXE.
  - Otherwise select 01 if RegWriteW, RdW≠0 and RdW==RsXE.
  - Otherwise select 00.
  - Memory-stage match beats Writeback-stage match.
  - Forwarding stays active in every state.
- Internal conditions:
  - lwStall = ResultSrcE0 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D) & ~PCSrcE. A taken branch squashes the Decode instruction, so no bubble is needed.
  - memStall = MemReqM & ~MemReadyM.
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: memory access outstanding.
  - HALT: memory timeout; pipeline frozen.
- RUN outputs:
  - StallF = StallD = lwStall | memStall.
  - StallE = StallM = FlushW = memStall.
  - FlushD = PCSrcE & ~memStall.
  - FlushE = (lwStall | PCSrcE) & ~memStall.
  - A frozen Execute stage keeps its branch, so its flush re-asserts once memory is ready.
- RUN transition: memStall → MEM_WAIT, waitcnt ← 1.
- MEM_WAIT outputs: same equations as RUN.
- MEM_WAIT transitions:
  - ~memStall → RUN, waitcnt ← 0.
  - memStall and waitcnt == MEM_TIMEOUT−1 → HALT.
  - Otherwise waitcnt ← waitcnt+1.
- HALT:
  - All Stall* = 1, FlushW = 1, FlushD = FlushE = 0, Halted = 1.
  - Only rst leaves HALT.
- Performance counters:
  - Increment each cycle their condition holds; wrap modulo 2^CNT_WIDTH.
  - Continue counting in HALT: StallCycles increments, FlushCount does not.
- Reset (synchronous):
  - State ← RUN, waitcnt ← 0, Halted ← 0, counters ← 0.
  - Combinational outputs follow the RUN equations during and immediately after reset.
  - rst asserted mid-MEM_WAIT or in HALT returns to RUN on the next edge.
- Simultaneous events:
  - MemReadyM=1 with MemReqM=1 in the same cycle means no stall.
  - Load-use together with memStall: the memory stall dominates; the load-use bubble is inserted on the first non-stalled cycle.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum (FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10).
  - hz_state_t enum (RUN, MEM_WAIT, HALT).
  - Constant REG_X0 = 5'd0.
- Sub-module forward_select, instantiated twice (operand A and operand B), computes one fwd_sel_t from RsXE, RdM, RdW, RegWriteM and RegWriteW.

Test Plan:
- Forward priority: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 → ForwardAE=10. Then RegWriteM=0 → ForwardAE=01. Then RdM=RdW=0 with both writes enabled → ForwardAE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7, PCSrcE=0 → StallF=StallD=FlushE=1, FlushD=0, StallCycles +1. With RdE=0 → no stall.
- Branch flush: PCSrcE=1 alongside the load-use condition → FlushD=FlushE=1, StallF=0, FlushCount +1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 → Stall F/D/E/M and FlushW high for exactly 3 cycles, state returns to RUN, StallCycles=3. A concurrent PCSrcE=1 produces FlushD only in the 4th cycle.
- Timeout: MEM_TIMEOUT=4, MemReadyM held 0 → HALT entered after 4 not-ready cycles, Halted=1 and all stalls held. Driving MemReadyM=1 has no effect; rst for one cycle → Halted=0, counters=0, state RUN.
- Counter wrap: CNT_WIDTH=4, hold lwStall for 17 cycles → StallCycles=1.
